// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the flappy-box game controller.
//   - game_state_t : FSM encodings, also driven out as game_State
//   - screen bounds of the visible VGA window (pixel / line numbers)
//   - default gap-midpoint range, widths and score ceiling
//   - lowest_one() : isolates the lowest set bit of the 3-bit pipe request vector
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_DYING = 2'b10,
    ST_OVER  = 2'b11
  } game_state_t;

  localparam int H_VIS_START  = 113;
  localparam int H_VIS_END    = 751;
  localparam int V_VIS_START  = 36;
  localparam int V_VIS_END    = 514;

  localparam int MID_TOP_DEF  = 90;
  localparam int MID_SPAN_DEF = 370;

  localparam int GAP_W        = 11;
  localparam int PIPE_N       = 3;
  localparam int SCORE_W      = 10;
  localparam int SCORE_MAX    = 999;

  // Two's-complement trick: v & -v keeps only the lowest set bit.
  function automatic logic [PIPE_N-1:0] lowest_one(input logic [PIPE_N-1:0] v);
    return v & (~v + PIPE_N'(1));
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: bundle between the game sequencer and the
// motion/collision/render datapath.
//   master (sequencer): drives tick, pipe_Enable, pipe_Spawn, gap_Mid,
//                       game_State, game_Over, score;
//                       receives collision, pipe_Exit, pipe_Passed.
//   slave  (datapath) : the mirror image.
interface game_sequencer_if;
  import game_pkg::*;

  logic                collision;
  logic [PIPE_N-1:0]   pipe_Exit;
  logic [PIPE_N-1:0]   pipe_Passed;

  logic                tick;
  logic [PIPE_N-1:0]   pipe_Enable;
  logic [PIPE_N-1:0]   pipe_Spawn;
  logic [GAP_W-1:0]    gap_Mid;
  logic [1:0]          game_State;
  logic                game_Over;
  logic [SCORE_W-1:0]  score;

  modport master (
    input  collision, pipe_Exit, pipe_Passed,
    output tick, pipe_Enable, pipe_Spawn, gap_Mid, game_State, game_Over, score
  );

  modport slave (
    output collision, pipe_Exit, pipe_Passed,
    input  tick, pipe_Enable, pipe_Spawn, gap_Mid, game_State, game_Over, score
  );

endinterface

// File: rtl/game_sequencer_spawn_lfsr.sv
// spawn_lfsr: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) and the
// range reduction that turns it into a pipe gap midpoint.
//   clkHz   in  clock
//   clr_n   in  async active-low reset (reloads LFSR_SEED, clears gap_Mid)
//   clear   in  sync clear of gap_Mid only; the LFSR keeps running
//   load    in  capture a new midpoint (asserted together with a spawn grant)
//   gap_Mid out registered midpoint in [MID_TOP, MID_TOP+MID_SPAN-1]
module spawn_lfsr
  import game_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MID_TOP   = MID_TOP_DEF,
  parameter int          MID_SPAN  = MID_SPAN_DEF
) (
  input  logic             clkHz,
  input  logic             clr_n,
  input  logic             clear,
  input  logic             load,
  output logic [GAP_W-1:0] gap_Mid
);

  logic [15:0] lfsr_q;
  logic        fb;

  // Bit n of the tap list maps to index n-1 in a left-shifting register.
  assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // A 9-bit draw spans 0..511; one conditional subtract folds it into 0..MID_SPAN-1.
  function automatic logic [GAP_W-1:0] reduce_mid(input logic [8:0] r);
    logic [8:0] m;
    m = (r >= 9'(MID_SPAN)) ? (r - 9'(MID_SPAN)) : r;
    return GAP_W'(MID_TOP) + GAP_W'(m);
  endfunction

  always_ff @(posedge clkHz or negedge clr_n) begin
    if (!clr_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= {lfsr_q[14:0], fb};
  end

  always_ff @(posedge clkHz or negedge clr_n) begin
    if (!clr_n)     gap_Mid <= '0;
    else if (clear) gap_Mid <= '0;
    else if (load)  gap_Mid <= reduce_mid(lfsr_q[8:0]);
  end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: top-level controller for the VGA flappy-box game.
// Sequences IDLE/PLAY/DYING/OVER, strobes the motion datapath once per frame,
// schedules staggered pipe release and respawn with random gap midpoints, and
// keeps a saturating score.
//   clkHz      in  system/pixel clock
//   clr_n      in  async active-low reset
//   h_Counter  in  VGA horizontal counter
//   v_Counter  in  VGA vertical counter
//   btn_U      in  start/flap button (asynchronous level)
//   restart    in  synchronous restart request (level)
//   dp         master side of game_sequencer_if (datapath handshake/outputs)
module game_sequencer
  import game_pkg::*;
#(
  parameter int          TICK_LINE    = 515,
  parameter int          PIPE2_DELAY  = 115,
  parameter int          PIPE3_DELAY  = 230,
  parameter int          DEATH_FRAMES = 60,
  parameter int          MID_TOP      = MID_TOP_DEF,
  parameter int          MID_SPAN     = MID_SPAN_DEF,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clkHz,
  input  logic       clr_n,
  input  logic [9:0] h_Counter,
  input  logic [9:0] v_Counter,
  input  logic       btn_U,
  input  logic       restart,
  game_sequencer_if.master dp
);

  localparam int DC_W = $clog2(DEATH_FRAMES + 1);

  game_state_t         state_q, state_d;
  logic                btn_s1, btn_s2, btn_d, btn_Rise;
  logic                frame_Hit;
  logic [15:0]         frame_Cnt;
  logic [DC_W-1:0]     death_Cnt;
  logic [PIPE_N-1:0]   pend_q, pipe_Enable_q, pipe_Spawn_q;
  logic [SCORE_W-1:0]  score_q;

  logic                in_play, stay_play, enter_play, enter_dying, tick_w;
  logic [PIPE_N-1:0]   delay_req, exit_req, spawn_req, grant;

  // Adds one per set pipe_Passed bit, clamped at SCORE_MAX.
  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s,
                                                   input logic [PIPE_N-1:0]  p);
    logic [SCORE_W+1:0] sum;
    sum = (SCORE_W+2)'(s) + (SCORE_W+2)'(p[0]) + (SCORE_W+2)'(p[1]) + (SCORE_W+2)'(p[2]);
    return (sum > (SCORE_W+2)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
  endfunction

  // Button synchroniser, one extra flop for the rising-edge detector.
  always_ff @(posedge clkHz or negedge clr_n) begin
    if (!clr_n) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      btn_d     <= 1'b0;
      frame_Hit <= 1'b0;
    end else begin
      btn_s1    <= btn_U;
      btn_s2    <= btn_s1;
      btn_d     <= btn_s2;
      frame_Hit <= (h_Counter == 10'd0) && (v_Counter == 10'(TICK_LINE));
    end
  end

  assign btn_Rise = btn_s2 & ~btn_d;

  always_ff @(posedge clkHz or negedge clr_n) begin
    if (!clr_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (btn_Rise)                               state_d = ST_PLAY;
      ST_PLAY:  if (frame_Hit && dp.collision)              state_d = ST_DYING;
      ST_DYING: if (frame_Hit && (death_Cnt == DC_W'(1)))   state_d = ST_OVER;
      ST_OVER:  if (btn_Rise)                               state_d = ST_IDLE;
      default:                                              state_d = ST_IDLE;
    endcase
    if (restart) state_d = ST_IDLE;
  end

  // Spawn requests: pending bits plus this cycle's new requests, so a request
  // raised now is granted at this same edge. Grants happen only while the
  // game stays in PLAY; leaving PLAY drops everything pending.
  always_comb begin
    in_play     = (state_q == ST_PLAY);
    stay_play   = in_play && (state_d == ST_PLAY);
    enter_play  = (state_q == ST_IDLE) && (state_d == ST_PLAY);
    enter_dying = in_play && (state_d == ST_DYING);
    tick_w      = frame_Hit && in_play;
    delay_req   = '0;
    if (tick_w && (frame_Cnt == 16'(PIPE2_DELAY - 1))) delay_req[1] = 1'b1;
    if (tick_w && (frame_Cnt == 16'(PIPE3_DELAY - 1))) delay_req[2] = 1'b1;
    exit_req    = in_play ? (dp.pipe_Exit & pipe_Enable_q) : '0;
    spawn_req   = pend_q | exit_req | delay_req;
    grant       = stay_play ? lowest_one(spawn_req) : '0;
  end

  always_ff @(posedge clkHz or negedge clr_n) begin
    if (!clr_n) begin
      frame_Cnt     <= '0;
      death_Cnt     <= '0;
      pend_q        <= '0;
      pipe_Enable_q <= '0;
      pipe_Spawn_q  <= '0;
      score_q       <= '0;
    end else if (restart) begin
      frame_Cnt     <= '0;
      death_Cnt     <= '0;
      pend_q        <= '0;
      pipe_Enable_q <= '0;
      pipe_Spawn_q  <= '0;
      score_q       <= '0;
    end else begin
      pipe_Spawn_q  <= grant;
      pipe_Enable_q <= stay_play ? (pipe_Enable_q | grant) : '0;
      if (enter_play) begin
        frame_Cnt <= '0;
        score_q   <= '0;
        pend_q    <= PIPE_N'(1);
      end else begin
        if (tick_w && (frame_Cnt != 16'hFFFF)) frame_Cnt <= frame_Cnt + 16'd1;
        if (in_play) score_q <= sat_score(score_q, dp.pipe_Passed);
        pend_q <= stay_play ? (spawn_req & ~grant) : '0;
      end
      if (enter_dying)
        death_Cnt <= DC_W'(DEATH_FRAMES);
      else if ((state_q == ST_DYING) && frame_Hit && (death_Cnt != '0))
        death_Cnt <= death_Cnt - DC_W'(1);
    end
  end

  spawn_lfsr #(
    .LFSR_SEED (LFSR_SEED),
    .MID_TOP   (MID_TOP),
    .MID_SPAN  (MID_SPAN)
  ) u_spawn_lfsr (
    .clkHz   (clkHz),
    .clr_n   (clr_n),
    .clear   (restart),
    .load    (|grant),
    .gap_Mid (dp.gap_Mid)
  );

  assign dp.tick        = tick_w;
  assign dp.pipe_Enable = pipe_Enable_q;
  assign dp.pipe_Spawn  = pipe_Spawn_q;
  assign dp.game_State  = state_q;
  assign dp.game_Over   = state_q[1];
  assign dp.score       = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed bench for game_sequencer. Drives the VGA
// counters directly (one frame_Hit every three clocks) and checks the FSM,
// pipe scheduling, score saturation, reset/restart and the gap midpoints
// against a reference LFSR.
module tb_game_sequencer;
  import game_pkg::*;

  logic       clkHz     = 1'b0;
  logic       clr_n     = 1'b0;
  logic [9:0] h_Counter = 10'd1;
  logic [9:0] v_Counter = 10'd0;
  logic       btn_U     = 1'b0;
  logic       restart   = 1'b0;

  game_sequencer_if dp();

  game_sequencer dut (
    .clkHz     (clkHz),
    .clr_n     (clr_n),
    .h_Counter (h_Counter),
    .v_Counter (v_Counter),
    .btn_U     (btn_U),
    .restart   (restart),
    .dp        (dp)
  );

  always #5 clkHz = ~clkHz;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference LFSR; m_prev is the value the DUT sampled at the last edge.
  logic [15:0] m_lfsr, m_prev;
  always @(posedge clkHz or negedge clr_n) begin
    if (!clr_n) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  function automatic int exp_gap(input logic [15:0] l);
    int r;
    r = int'(l[8:0]);
    if (r >= 370) r = r - 370;
    return 90 + r;
  endfunction

  int n_tick = 0, n_spawn = 0, n_gap_bad = 0, n_range_bad = 0, n_oh_bad = 0;
  always @(negedge clkHz) begin
    if (clr_n) begin
      if (dp.tick === 1'b1) n_tick <= n_tick + 1;
      if (dp.pipe_Spawn !== 3'b000) begin
        n_spawn <= n_spawn + 1;
        if (int'(dp.gap_Mid) != exp_gap(m_prev)) n_gap_bad <= n_gap_bad + 1;
        if (dp.gap_Mid < 11'd90 || dp.gap_Mid > 11'd459) n_range_bad <= n_range_bad + 1;
        if (!$onehot(dp.pipe_Spawn)) n_oh_bad <= n_oh_bad + 1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clkHz);
      #1;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      h_Counter = 10'd0; v_Counter = 10'd515;
      cyc();
      h_Counter = 10'd1; v_Counter = 10'd0;
      cyc(2);
    end
  endtask

  // Holds btn_U for 3 clocks; lat = clocks until game_State == target (99 = never).
  task automatic press(input logic [1:0] target, output int lat);
    lat = 99;
    btn_U = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i == 3) btn_U = 1'b0;
      if (lat == 99 && dp.game_State == target) lat = i;
    end
  endtask

  task automatic pulse(input logic [2:0] p);
    dp.pipe_Passed = p;
    cyc();
    dp.pipe_Passed = 3'b000;
    cyc();
  endtask

  int lat, s0, t0;
  logic [10:0] g1, g2;

  initial begin
    dp.collision   = 1'b0;
    dp.pipe_Exit   = 3'b000;
    dp.pipe_Passed = 3'b000;

    // Reset and start
    cyc(3);
    chk("rst_state", dp.game_State, 0);
    chk("rst_outs", {dp.tick, dp.pipe_Enable, dp.pipe_Spawn, dp.game_Over, dp.score, dp.gap_Mid}, 0);
    clr_n = 1'b1;
    cyc(2);
    s0 = n_spawn;
    press(ST_PLAY, lat);
    chk("play_lat_le4", lat <= 4, 1);
    chk("play_state", dp.game_State, 1);
    chk("first_spawn_cnt", n_spawn - s0, 1);
    chk("first_spawn_en", dp.pipe_Enable, 3'b001);
    chk("first_score", dp.score, 0);

    // Staggered release of pipes 2 and 3
    t0 = n_tick;
    s0 = n_spawn;
    frames(114);
    chk("no_early_spawn", n_spawn - s0, 0);
    h_Counter = 10'd0; v_Counter = 10'd515;
    cyc();
    h_Counter = 10'd1; v_Counter = 10'd0;
    chk("tick_115", dp.tick, 1);
    cyc();
    chk("spawn_pipe2", dp.pipe_Spawn, 3'b010);
    cyc();
    frames(114);
    h_Counter = 10'd0; v_Counter = 10'd515;
    cyc();
    h_Counter = 10'd1; v_Counter = 10'd0;
    cyc();
    chk("spawn_pipe3", dp.pipe_Spawn, 3'b100);
    cyc();
    chk("tick_count_230", n_tick - t0, 230);
    chk("enable_all", dp.pipe_Enable, 3'b111);

    // Simultaneous exits and absorption of a repeated request
    dp.pipe_Exit = 3'b101;
    cyc();
    dp.pipe_Exit = 3'b000;
    chk("exit101_first", dp.pipe_Spawn, 3'b001);
    g1 = dp.gap_Mid;
    cyc();
    chk("exit101_second", dp.pipe_Spawn, 3'b100);
    g2 = dp.gap_Mid;
    cyc();
    chk("exit101_done", dp.pipe_Spawn, 3'b000);
    chk("exit101_gap_differs", g1 != g2, 1);
    dp.pipe_Exit = 3'b011;
    cyc();
    dp.pipe_Exit = 3'b010;
    chk("absorb_first", dp.pipe_Spawn, 3'b001);
    cyc();
    dp.pipe_Exit = 3'b000;
    chk("absorb_second", dp.pipe_Spawn, 3'b010);
    cyc();
    chk("absorb_done", dp.pipe_Spawn, 3'b000);

    // Score: +2 on a double pulse, saturation at 999
    chk("score_start", dp.score, 0);
    pulse(3'b011);
    chk("score_plus2", dp.score, 2);
    repeat (996) pulse(3'b001);
    chk("score_998", dp.score, 998);
    pulse(3'b011);
    chk("score_sat_pair", dp.score, 999);
    pulse(3'b001);
    chk("score_sat_one", dp.score, 999);

    // Collision, DYING, OVER, back to IDLE
    dp.collision = 1'b1;
    cyc(2);
    dp.collision = 1'b0;
    chk("coll_between_frames", dp.game_State, 1);
    dp.collision = 1'b1;
    frames(1);
    dp.collision = 1'b0;
    chk("dying_state", dp.game_State, 2);
    chk("dying_enable", dp.pipe_Enable, 0);
    chk("dying_over_flag", dp.game_Over, 1);
    t0 = n_tick;
    pulse(3'b011);
    chk("score_frozen", dp.score, 999);
    frames(59);
    chk("dying_59", dp.game_State, 2);
    frames(1);
    chk("over_60", dp.game_State, 3);
    chk("over_flag", dp.game_Over, 1);
    chk("no_tick_dying", n_tick - t0, 0);
    press(ST_IDLE, lat);
    chk("idle_lat_le4", lat <= 4, 1);
    chk("idle_over_flag", dp.game_Over, 0);

    // Asynchronous reset mid-PLAY
    press(ST_PLAY, lat);
    chk("replay_state", dp.game_State, 1);
    chk("replay_score", dp.score, 0);
    pulse(3'b001);
    chk("replay_score1", dp.score, 1);
    @(posedge clkHz);
    #2;
    clr_n = 1'b0;
    #1;
    chk("async_rst_state", dp.game_State, 0);
    chk("async_rst_outs", {dp.tick, dp.pipe_Enable, dp.pipe_Spawn, dp.game_Over, dp.score, dp.gap_Mid}, 0);
    cyc(2);
    clr_n = 1'b1;
    cyc(2);

    // Restart from DYING
    press(ST_PLAY, lat);
    pulse(3'b001);
    dp.collision = 1'b1;
    frames(1);
    dp.collision = 1'b0;
    chk("pre_restart_dying", dp.game_State, 2);
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("restart_idle", dp.game_State, 0);
    chk("restart_outs", {dp.tick, dp.pipe_Enable, dp.pipe_Spawn, dp.game_Over, dp.score, dp.gap_Mid}, 0);

    // LFSR sweep through repeated respawns of pipe 1
    press(ST_PLAY, lat);
    s0 = n_spawn;
    repeat (300) begin
      dp.pipe_Exit = 3'b001;
      cyc();
      dp.pipe_Exit = 3'b000;
      cyc();
    end
    chk("sweep_spawns", n_spawn - s0, 300);
    chk("gap_out_of_range", n_range_bad, 0);
    chk("gap_vs_model", n_gap_bad, 0);
    chk("spawn_not_onehot", n_oh_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
